fp_to_int_pipe: RTL and testbench
=================================

Name: fp_to_int_pipe

Overview:
- Pipelined converter from IEEE-754 single-precision floating point to a signed two's-complement integer.
- It is the decode direction of the FP datapath: it consumes packed 32-bit results from the FP add/sub unit and unpacks sign, exponent and mantissa.
- It aligns, rounds and saturates the value into an INT_W-bit integer, then hands it downstream over a valid/ready interface.
- Three register stages; throughput of one conversion per cycle.

Parameters:
- INT_W, 32: output integer width; legal range 2..32.

Ports:
- CLK  input  1  clock; rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- A  input  32  single-precision operand: sign [31], exponent [30:23], fraction [22:0].
- Trunc  input  1  rounding mode, sampled with A: 0 = round to nearest even, 1 = truncate toward zero.
- InValid  input  1  A and Trunc are valid.
- InReady  output  1  block accepts A this cycle.
- Z  output  INT_W  converted signed integer.
- Invalid  output  1  operand was NaN.
- Overflow  output  1  result saturated (out-of-range value or infinity).
- Inexact  output  1  nonzero bits were discarded by rounding.
- OutValid  output  1  Z and flags are valid.
- OutReady  input  1  downstream accepts Z this cycle.

Behaviour:
- Reset: all stage valid bits = 0; OutValid = 0; Z = 0; flags = 0. InReady = 1 one cycle after reset release at the latest. Reset mid-stream discards all in-flight data.
- Handshake and pipeline control:
  - Transfer in: InValid && InReady at the rising edge.
  - Transfer out: OutValid && OutReady at the rising edge.
  - Per-stage elastic control: ready_k = !valid_k || ready_(k+1), with ready_4 = OutReady and InReady = ready_1 (combinational).
  - Bubbles collapse.
- Output hold: while OutValid && !OutReady, Z and the flags hold stable.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Latency: data accepted at edge t presents OutValid after edge t+2, provided no stall occurs.
- Stage 1 (unpack):
  - Register S, E, M[23:0] = {E != 0, frac}, and Trunc.
  - Classify: NaN (E = 255, frac != 0), Inf (E = 255, frac = 0), Zero/denormal (E = 0).
- Stage 2 (align): e = E - 127.
  - e < -1: integer part 0; guard = 0; sticky = (M != 0).
  - e = -1: integer part 0; guard = M[23]; sticky = |M[22:0].
  - 0 <= e <= 23: integer = M >> (23 - e); guard = first discarded bit; sticky = OR of the remaining discarded bits.
  - 24 <= e <= INT_W - 1: integer = M << (e - 23); guard = sticky = 0.
  - e >= INT_W: set a pre-overflow marker.
  - Denormals follow the e < -1 path.
- Stage 3 (round, sign, saturate):
  - RNE: increment when guard && (sticky || lsb).
  - Trunc = 1: never increment.
  - Inexact = guard || sticky, for finite, non-saturated results only.
  - Let magnitude = rounded integer part.
  - S = 0: if magnitude > 2^(INT_W-1) - 1, or the pre-overflow marker is set, or Inf: Z = 2^(INT_W-1) - 1 and Overflow = 1.
  - S = 1: if magnitude > 2^(INT_W-1), or the pre-overflow marker is set, or Inf: Z = -2^(INT_W-1) and Overflow = 1.
  - Otherwise Z = S ? -magnitude : magnitude.
  - Overflow is evaluated after rounding. An exact -2^(INT_W-1) is not an overflow.
  - NaN (either sign): Z = 2^(INT_W-1) - 1; Invalid = 1; Overflow = 0; Inexact = 0.
  - Zero (either sign): Z = 0, no flags.
- Internal widths: the magnitude path is INT_W + 1 bits, so a rounding carry is never lost.

Test Plan (INT_W = 32):
- Rounding:
  - 0x3FC00000 (1.5): RNE gives Z = 2, Inexact = 1; Trunc gives Z = 1, Inexact = 1.
  - 0x40200000 (2.5): RNE gives Z = 2.
  - 0xC0200000 (-2.5): RNE gives Z = 0xFFFFFFFE.
  - 0x40400000 (3.0): Z = 3, no flags.
- Saturation and special values:
  - 0x4F000000 (2^31): Z = 0x7FFFFFFF, Overflow = 1.
  - 0xCF000000: Z = 0x80000000, no flags.
  - 0x4EFFFFFF: Z = 0x7FFFFF80, no flags.
  - 0xFF800000: Z = 0x80000000, Overflow = 1.
  - 0x7FC00000: Z = 0x7FFFFFFF, Invalid = 1.
- Small values:
  - 0x3F000000 (0.5) RNE: Z = 0, Inexact = 1.
  - 0x3F000001 RNE: Z = 1.
  - 0xBF400000 (-0.75) RNE: Z = 0xFFFFFFFF.
  - 0x00000001 (denormal): Z = 0, Inexact = 1.
  - 0x80000000: Z = 0, no flags.
- Latency: single accept at edge t with OutReady = 1 -> OutValid first high after edge t+2 for exactly one cycle.
- Backpressure:
  - Stimulus: 8 back-to-back inputs (1.0 .. 8.0 as floats); OutReady low for 4 cycles once the first result appears.
  - Required: InReady drops after the pipeline fills; Z is held stable during the stall; outputs are 1..8 in order with no gaps or duplicates once OutReady returns; full rate resumes.
- Reset mid-stream: assert RST with 3 conversions in flight -> OutValid = 0 and Z = 0 immediately (asynchronously); no stale result emerges after release; the next input converts correctly.

Source files
------------

// File: rtl/fp_to_int_pipe_if.sv
// Stream interface for the float-to-integer converter: operand side plus result side.
// A beat moves on a rising edge only when its valid and ready are both high; valid never waits on ready.
interface fp_to_int_pipe_if #(
    parameter int INT_W = 32
);
    logic [31:0]      A;
    logic             Trunc;
    logic             InValid;
    logic             InReady;
    logic [INT_W-1:0] Z;
    logic             Invalid;
    logic             Overflow;
    logic             Inexact;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output A, Trunc, InValid, OutReady,
        input  InReady, Z, Invalid, Overflow, Inexact, OutValid
    );

    modport slave (
        input  A, Trunc, InValid, OutReady,
        output InReady, Z, Invalid, Overflow, Inexact, OutValid
    );
endinterface

// File: rtl/fp_to_int_pipe.sv
// Three-stage IEEE-754 single to signed INT_W-bit integer converter.
// Stages: unpack/classify, align with guard/sticky, round/sign/saturate.
module fp_to_int_pipe #(
    parameter int INT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    fp_to_int_pipe_if.slave  io
);
    localparam int MAG_W = INT_W + 1;
    localparam logic [MAG_W-1:0] POS_MAX   = MAG_W'((64'd1 << (INT_W - 1)) - 64'd1);
    localparam logic [MAG_W-1:0] NEG_MAX   = MAG_W'(64'd1 << (INT_W - 1));
    localparam logic [INT_W-1:0] Z_POS_SAT = INT_W'((64'd1 << (INT_W - 1)) - 64'd1);
    localparam logic [INT_W-1:0] Z_NEG_SAT = INT_W'(64'd1 << (INT_W - 1));

    // stage 1: unpacked operand
    logic        v1_q, v1_d;
    logic        sign1_q, sign1_d;
    logic [7:0]  exp1_q, exp1_d;
    logic [23:0] man1_q, man1_d;
    logic        trunc1_q, trunc1_d;
    logic        nan1_q, nan1_d;
    logic        inf1_q, inf1_d;

    // stage 2: aligned integer part plus rounding bits
    logic             v2_q, v2_d;
    logic             sign2_q, sign2_d;
    logic             trunc2_q, trunc2_d;
    logic             nan2_q, nan2_d;
    logic             inf2_q, inf2_d;
    logic             povf2_q, povf2_d;
    logic [MAG_W-1:0] mag2_q, mag2_d;
    logic             grd2_q, grd2_d;
    logic             stk2_q, stk2_d;

    // stage 3: final result
    logic             v3_q, v3_d;
    logic [INT_W-1:0] z3_q, z3_d;
    logic             inv3_q, inv3_d;
    logic             ovf3_q, ovf3_d;
    logic             inx3_q, inx3_d;

    logic rdy1, rdy2, rdy3;

    assign rdy3 = !v3_q || io.OutReady;
    assign rdy2 = !v2_q || rdy3;
    assign rdy1 = !v1_q || rdy2;

    assign io.InReady  = rdy1;
    assign io.OutValid = v3_q;
    assign io.Z        = z3_q;
    assign io.Invalid  = inv3_q;
    assign io.Overflow = ovf3_q;
    assign io.Inexact  = inx3_q;

    logic signed [9:0] exp_unb;
    logic [4:0]        sh_r;
    logic [4:0]        sh_l;
    logic [47:0]       ext_r;
    logic              inc;
    logic [MAG_W-1:0]  mag_rnd;

    always_comb begin
        v1_d     = v1_q;
        sign1_d  = sign1_q;
        exp1_d   = exp1_q;
        man1_d   = man1_q;
        trunc1_d = trunc1_q;
        nan1_d   = nan1_q;
        inf1_d   = inf1_q;
        if (rdy1) begin
            v1_d = io.InValid;
            if (io.InValid) begin
                sign1_d  = io.A[31];
                exp1_d   = io.A[30:23];
                man1_d   = {|io.A[30:23], io.A[22:0]};
                trunc1_d = io.Trunc;
                nan1_d   = (&io.A[30:23]) && (|io.A[22:0]);
                inf1_d   = (&io.A[30:23]) && !(|io.A[22:0]);
            end
        end
    end

    always_comb begin
        exp_unb = $signed({2'b00, exp1_q}) - 10'sd127;
        sh_r    = 5'(10'sd23 - exp_unb);
        sh_l    = 5'(exp_unb - 10'sd23);
        ext_r   = {man1_q, 24'd0} >> sh_r;

        v2_d     = v2_q;
        sign2_d  = sign2_q;
        trunc2_d = trunc2_q;
        nan2_d   = nan2_q;
        inf2_d   = inf2_q;
        povf2_d  = povf2_q;
        mag2_d   = mag2_q;
        grd2_d   = grd2_q;
        stk2_d   = stk2_q;
        if (rdy2) begin
            v2_d = v1_q;
            if (v1_q) begin
                sign2_d  = sign1_q;
                trunc2_d = trunc1_q;
                nan2_d   = nan1_q;
                inf2_d   = inf1_q;
                povf2_d  = 1'b0;
                mag2_d   = '0;
                grd2_d   = 1'b0;
                stk2_d   = 1'b0;
                // Out-of-range exponents are tested before the shift paths so small INT_W never shifts past MAG_W.
                if (exp_unb < -10'sd1) begin
                    stk2_d = |man1_q;
                end else if (exp_unb == -10'sd1) begin
                    grd2_d = man1_q[23];
                    stk2_d = |man1_q[22:0];
                end else if (exp_unb >= $signed(10'(INT_W))) begin
                    povf2_d = 1'b1;
                end else if (exp_unb <= 10'sd23) begin
                    mag2_d = MAG_W'(ext_r[47:24]);
                    grd2_d = ext_r[23];
                    stk2_d = |ext_r[22:0];
                end else begin
                    mag2_d = MAG_W'(man1_q) << sh_l;
                end
            end
        end
    end

    always_comb begin
        inc     = !trunc2_q && grd2_q && (stk2_q || mag2_q[0]);
        mag_rnd = mag2_q + MAG_W'(inc);

        v3_d   = v3_q;
        z3_d   = z3_q;
        inv3_d = inv3_q;
        ovf3_d = ovf3_q;
        inx3_d = inx3_q;
        if (rdy3) begin
            v3_d = v2_q;
            if (v2_q) begin
                inv3_d = 1'b0;
                ovf3_d = 1'b0;
                inx3_d = 1'b0;
                if (nan2_q) begin
                    z3_d   = Z_POS_SAT;
                    inv3_d = 1'b1;
                end else if (sign2_q) begin
                    if (inf2_q || povf2_q || (mag_rnd > NEG_MAX)) begin
                        z3_d   = Z_NEG_SAT;
                        ovf3_d = 1'b1;
                    end else begin
                        z3_d   = -mag_rnd[INT_W-1:0];
                        inx3_d = grd2_q || stk2_q;
                    end
                end else begin
                    if (inf2_q || povf2_q || (mag_rnd > POS_MAX)) begin
                        z3_d   = Z_POS_SAT;
                        ovf3_d = 1'b1;
                    end else begin
                        z3_d   = mag_rnd[INT_W-1:0];
                        inx3_d = grd2_q || stk2_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q     <= 1'b0;
            sign1_q  <= 1'b0;
            exp1_q   <= '0;
            man1_q   <= '0;
            trunc1_q <= 1'b0;
            nan1_q   <= 1'b0;
            inf1_q   <= 1'b0;
            v2_q     <= 1'b0;
            sign2_q  <= 1'b0;
            trunc2_q <= 1'b0;
            nan2_q   <= 1'b0;
            inf2_q   <= 1'b0;
            povf2_q  <= 1'b0;
            mag2_q   <= '0;
            grd2_q   <= 1'b0;
            stk2_q   <= 1'b0;
            v3_q     <= 1'b0;
            z3_q     <= '0;
            inv3_q   <= 1'b0;
            ovf3_q   <= 1'b0;
            inx3_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            sign1_q  <= sign1_d;
            exp1_q   <= exp1_d;
            man1_q   <= man1_d;
            trunc1_q <= trunc1_d;
            nan1_q   <= nan1_d;
            inf1_q   <= inf1_d;
            v2_q     <= v2_d;
            sign2_q  <= sign2_d;
            trunc2_q <= trunc2_d;
            nan2_q   <= nan2_d;
            inf2_q   <= inf2_d;
            povf2_q  <= povf2_d;
            mag2_q   <= mag2_d;
            grd2_q   <= grd2_d;
            stk2_q   <= stk2_d;
            v3_q     <= v3_d;
            z3_q     <= z3_d;
            inv3_q   <= inv3_d;
            ovf3_q   <= ovf3_d;
            inx3_q   <= inx3_d;
        end
    end
endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench for fp_to_int_pipe at INT_W = 32: conversions, latency, backpressure, mid-stream reset.
// Expected results are {Invalid, Overflow, Inexact, Z}.
module tb_fp_to_int_pipe;
    localparam int INT_W = 32;
    localparam int EW    = INT_W + 3;
    localparam int NV    = 26;

    localparam logic [31:0] VA [NV] = '{
        32'h3FC00000, 32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h40400000,
        32'h4F000000, 32'hCF000000, 32'h4EFFFFFF, 32'hFF800000, 32'h7FC00000,
        32'h3F000000, 32'h3F000001, 32'hBF400000, 32'h00000001, 32'h80000000,
        32'h7F800000, 32'hFFC00000, 32'hC0200000, 32'h3FE00000, 32'h40600000,
        32'h4B800001, 32'h3F7FFFFF, 32'hCF000001, 32'hC1A80000, 32'h4F800000,
        32'hBF000000
    };
    localparam logic VT [NV] = '{
        1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0
    };
    localparam logic [EW-1:0] VE [NV] = '{
        {3'b001, 32'h00000002}, {3'b001, 32'h00000001}, {3'b001, 32'h00000002},
        {3'b001, 32'hFFFFFFFE}, {3'b000, 32'h00000003}, {3'b010, 32'h7FFFFFFF},
        {3'b000, 32'h80000000}, {3'b000, 32'h7FFFFF80}, {3'b010, 32'h80000000},
        {3'b100, 32'h7FFFFFFF}, {3'b001, 32'h00000000}, {3'b001, 32'h00000001},
        {3'b001, 32'hFFFFFFFF}, {3'b001, 32'h00000000}, {3'b000, 32'h00000000},
        {3'b010, 32'h7FFFFFFF}, {3'b100, 32'h7FFFFFFF}, {3'b001, 32'hFFFFFFFE},
        {3'b001, 32'h00000001}, {3'b001, 32'h00000004}, {3'b000, 32'h01000002},
        {3'b001, 32'h00000001}, {3'b010, 32'h80000000}, {3'b000, 32'hFFFFFFEB},
        {3'b010, 32'h7FFFFFFF}, {3'b001, 32'h00000000}
    };
    localparam logic [31:0] BP_A [8] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
    };

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_to_int_pipe_if #(.INT_W(INT_W)) io ();

    fp_to_int_pipe #(.INT_W(INT_W)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every output transfer is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && io.OutValid && io.OutReady) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {io.Invalid, io.Overflow, io.Inexact, io.Z}, mon_exp);
            end
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] a, input logic t, input logic [EW-1:0] e);
        int waited = 0;
        bit ok = 1'b0;
        io.InValid = 1'b1;
        io.A       = a;
        io.Trunc   = t;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (io.InReady) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic idle();
        io.InValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst         = 1'b1;
        io.InValid  = 1'b0;
        io.A        = '0;
        io.Trunc    = 1'b0;
        io.OutReady = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outvalid", 64'(io.OutValid), 64'd0);
        check("rst_z", 64'(io.Z), 64'd0);
        check("rst_flags", 64'({io.Invalid, io.Overflow, io.Inexact}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_inready", 64'(io.InReady), 64'd1);
        @(posedge clk);
        #1;

        // latency: one accept, result valid after edge t+2 for one cycle
        send(32'h40400000, 1'b0, {3'b000, 32'd3});
        idle();
        @(negedge clk); check("lat_t0", 64'(io.OutValid), 64'd0);
        @(negedge clk); check("lat_t1", 64'(io.OutValid), 64'd0);
        @(negedge clk); check("lat_t2", 64'(io.OutValid), 64'd1);
        @(negedge clk); check("lat_t3", 64'(io.OutValid), 64'd0);
        @(posedge clk);
        #1;

        // directed conversion table, back to back
        for (int i = 0; i < NV; i++) send(VA[i], VT[i], VE[i]);
        idle();
        drain();
        @(posedge clk);
        #1;

        // backpressure
        fork
            begin
                for (int i = 0; i < 8; i++) send(BP_A[i], 1'b0, {3'b000, 32'(i + 1)});
                idle();
            end
            begin
                int n = 0;
                while (!io.OutValid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first_seen", 64'(io.OutValid), 64'd1);
                @(posedge clk);
                #1 io.OutReady = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_hold_z", 64'(io.Z), 64'd2);
                    check("bp_hold_valid", 64'(io.OutValid), 64'd1);
                end
                check("bp_inready_drop", 64'(io.InReady), 64'd0);
                @(posedge clk);
                #1 io.OutReady = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    check("bp_no_gap", 64'(io.OutValid), 64'd1);
                end
            end
        join
        drain();
        @(posedge clk);
        #1;

        // reset with three conversions in flight
        io.OutReady = 1'b0;
        send(32'h40800000, 1'b0, {3'b000, 32'd4});
        send(32'h40A00000, 1'b0, {3'b000, 32'd5});
        send(32'h40C00000, 1'b0, {3'b000, 32'd6});
        idle();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outvalid", 64'(io.OutValid), 64'd0);
        check("rst_mid_z", 64'(io.Z), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        io.OutReady = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (io.OutValid) seen = 1;
        end
        check("rst_no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(32'h40400000, 1'b0, {3'b000, 32'd3});
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
